// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared constants, types and helpers for the fir tap-window producer.
//   DWIDTH : input sample width (signed)
//   CWIDTH : coefficient width (signed)
//   NTAPS  : window length (odd)
//   NUNIQ  : number of unique (symmetric) coefficients = (NTAPS+1)/2
//   tap_t  : one window element, sample sign-extended by one bit so the
//            symmetric fir can pre-add mirrored taps without overflow
//   coeff_t: one coefficient
//   state_t: feeder state machine encoding
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DWIDTH = 14;
    localparam int CWIDTH = 11;
    localparam int NTAPS  = 37;
    localparam int NUNIQ  = (NTAPS + 1) / 2;
    localparam int AWIDTH = 5;   // coefficient address width
    localparam int FWIDTH = 6;   // fill counter width, holds 0..NTAPS

    typedef logic signed [DWIDTH:0]   tap_t;
    typedef logic signed [CWIDTH-1:0] coeff_t;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Window position k uses the unique coefficient min(k, NTAPS-1-k).
    function automatic int mirror_index(input int k);
        return (k < NUNIQ) ? k : (NTAPS - 1 - k);
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// ---------------------------------------------------------------------------
// fir_coeff_bank
// Holds the NUNIQ unique coefficients, tracks which have been written and
// expands them into the full mirrored NTAPS-entry coefficient vector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr         : write strobe
//   ready      : write permission (high only while the feeder is loading)
//   addr       : unique coefficient index, values >= NUNIQ are ignored
//   data       : coefficient value
//   coeff      : mirrored coefficient vector, coeff[k] = reg[min(k,NTAPS-1-k)]
//   coeff_ok   : every unique coefficient has been written at least once
// ---------------------------------------------------------------------------
module fir_coeff_bank
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              ready,
    input  logic [AWIDTH-1:0] addr,
    input  coeff_t            data,
    output coeff_t            coeff [NTAPS],
    output logic              coeff_ok
);

    coeff_t           coeff_reg [NUNIQ];
    logic [NUNIQ-1:0] mask_reg;
    logic             wr_hit;

    // Out-of-range addresses are dropped entirely: no data, no mask bit.
    assign wr_hit = wr && ready && (addr < AWIDTH'(NUNIQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUNIQ; i++) begin
                coeff_reg[i] <= '0;
            end
            mask_reg <= '0;
        end else if (wr_hit) begin
            coeff_reg[addr] <= data;
            mask_reg[addr]  <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_mirror
            localparam int MI = mirror_index(gi);
            assign coeff[gi] = coeff_reg[MI];
        end
    endgenerate

    assign coeff_ok = &mask_reg;

endmodule

// File: rtl/fir_tap_feeder.sv
// ---------------------------------------------------------------------------
// fir_tap_feeder
// Producer side of the fir tap-window interface: shifts a serial sample
// stream into an NTAPS-deep parallel window and presents the mirrored
// coefficient vector alongside it. WIN_VALID pulses for one cycle after each
// accepted sample that leaves the window fully populated with fresh data.
// Optional feature macro: FIR_FEED_FLUSH_EN (adds the FLUSH input).
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   FLUSH      : (FIR_FEED_FLUSH_EN only) clear window, restart fill
//   EN         : run enable, low forces the load state and clears the window
//   S_DATA     : signed input sample
//   S_VALID    : sample valid
//   S_READY    : sample accept (combinational)
//   C_WR       : coefficient write strobe
//   C_ADDR     : unique coefficient index
//   C_DATA     : coefficient value
//   C_READY    : coefficient writes allowed (load state only)
//   TAP        : sample window, TAP[0] newest
//   COEFF      : mirrored coefficient vector
//   WIN_VALID  : one-cycle pulse per fresh full window
//   COEFF_OK   : all unique coefficients written
// ---------------------------------------------------------------------------
module fir_tap_feeder
    import fir_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST_N,
`ifdef FIR_FEED_FLUSH_EN
    input  logic                     FLUSH,
`endif
    input  logic                     EN,
    input  logic signed [DWIDTH-1:0] S_DATA,
    input  logic                     S_VALID,
    output logic                     S_READY,
    input  logic                     C_WR,
    input  logic [AWIDTH-1:0]        C_ADDR,
    input  coeff_t                   C_DATA,
    output logic                     C_READY,
    output tap_t                     TAP [NTAPS],
    output coeff_t                   COEFF [NTAPS],
    output logic                     WIN_VALID,
    output logic                     COEFF_OK
);

    state_t            state_reg;
    state_t            state_next;
    tap_t              tap_reg [NTAPS];
    logic [FWIDTH-1:0] fill_reg;
    logic              win_valid_reg;
    logic              s_ready;
    logic              c_ready;
    logic              accept;
    logic              flush;
    logic              last_fill;
    logic              clear_window;
    logic              coeff_ok;

`ifdef FIR_FEED_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign accept    = S_VALID && s_ready;
    // This accept completes the first full window after a (re)fill.
    assign last_fill = (state_reg == S_FILL) && (fill_reg == FWIDTH'(NTAPS - 1));

    // The window is held at zero while loading and wiped whenever the run is
    // interrupted; only the coefficients survive.
    assign clear_window = !EN || (state_reg == S_LOAD) ||
                          (flush && (state_reg != S_LOAD));

    fir_coeff_bank u_coeff_bank (
        .clk      (CLK),
        .rst_n    (RST_N),
        .wr       (C_WR),
        .ready    (c_ready),
        .addr     (C_ADDR),
        .data     (C_DATA),
        .coeff    (COEFF),
        .coeff_ok (coeff_ok)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= S_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!EN) begin
            state_next = S_LOAD;
        end else if (flush && (state_reg != S_LOAD)) begin
            state_next = S_FILL;
        end else begin
            case (state_reg)
                S_LOAD: if (coeff_ok) state_next = S_FILL;
                S_FILL: if (accept && last_fill) state_next = S_RUN;
                S_RUN:  state_next = S_RUN;
                default: state_next = S_LOAD;
            endcase
        end
    end

    // Output logic; a flushing cycle refuses the concurrent sample.
    always_comb begin
        s_ready = EN && (state_reg != S_LOAD) && !flush;
        c_ready = (state_reg == S_LOAD);
    end

    // Window shift register, fill counter and window-valid pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NTAPS; i++) begin
                tap_reg[i] <= '0;
            end
            fill_reg      <= '0;
            win_valid_reg <= 1'b0;
        end else begin
            win_valid_reg <= accept && (last_fill || (state_reg == S_RUN));
            if (clear_window) begin
                for (int i = 0; i < NTAPS; i++) begin
                    tap_reg[i] <= '0;
                end
                fill_reg <= '0;
            end else if (accept) begin
                tap_reg[0] <= {S_DATA[DWIDTH-1], S_DATA};
                for (int i = 1; i < NTAPS; i++) begin
                    tap_reg[i] <= tap_reg[i-1];
                end
                if (fill_reg < FWIDTH'(NTAPS)) begin
                    fill_reg <= fill_reg + 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_tap_out
            assign TAP[gi] = tap_reg[gi];
        end
    endgenerate

    assign S_READY   = s_ready;
    assign C_READY   = c_ready;
    assign WIN_VALID = win_valid_reg;
    assign COEFF_OK  = coeff_ok;

endmodule

// File: tb/tb_fir_tap_feeder.sv
module tb_fir_tap_feeder;
    import fir_pkg::*;

    logic                     CLK = 1'b0;
    logic                     RST_N;
    logic                     EN;
    logic signed [DWIDTH-1:0] S_DATA;
    logic                     S_VALID;
    logic                     S_READY;
    logic                     C_WR;
    logic [AWIDTH-1:0]        C_ADDR;
    coeff_t                   C_DATA;
    logic                     C_READY;
    tap_t                     TAP [NTAPS];
    coeff_t                   COEFF [NTAPS];
    logic                     WIN_VALID;
    logic                     COEFF_OK;
`ifdef FIR_FEED_FLUSH_EN
    logic                     FLUSH;
`endif

    always #5 CLK = ~CLK;

    fir_tap_feeder dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
`ifdef FIR_FEED_FLUSH_EN
        .FLUSH     (FLUSH),
`endif
        .EN        (EN),
        .S_DATA    (S_DATA),
        .S_VALID   (S_VALID),
        .S_READY   (S_READY),
        .C_WR      (C_WR),
        .C_ADDR    (C_ADDR),
        .C_DATA    (C_DATA),
        .C_READY   (C_READY),
        .TAP       (TAP),
        .COEFF     (COEFF),
        .WIN_VALID (WIN_VALID),
        .COEFF_OK  (COEFF_OK)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        tap_t newest;
        tap_t middle;
        tap_t oldest;
    } exp_t;

    exp_t   sb [$];          // expected windows, oldest first
    tap_t   model_win [$];   // model window, index 0 newest
    coeff_t cm [NUNIQ];      // model of the unique coefficients
    exp_t   mon_e;

    // Model of an accepted sample: shift, and queue the expected window
    // whenever the model window is full.
    task automatic model_accept(input tap_t v);
        exp_t e;
        model_win.push_front(v);
        if (model_win.size() > NTAPS) void'(model_win.pop_back());
        if (model_win.size() == NTAPS) begin
            e.newest = model_win[0];
            e.middle = model_win[18];
            e.oldest = model_win[NTAPS-1];
            sb.push_back(e);
        end
    endtask

    // Present one sample for one clock edge; returns #1 after that edge.
    task automatic send(input logic signed [DWIDTH-1:0] d);
        S_DATA  = d;
        S_VALID = 1'b1;
        model_accept({d[DWIDTH-1], d});
        @(posedge CLK); #1;
        S_VALID = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Scoreboard: every WIN_VALID pulse must match the oldest pending window.
    always @(negedge CLK) begin
        if (RST_N && WIN_VALID) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL win_unexpected: WIN_VALID=1 with no window pending, required 0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                if (TAP[0] !== mon_e.newest || TAP[18] !== mon_e.middle || TAP[NTAPS-1] !== mon_e.oldest) begin
                    failures++;
                    $display("FAIL win_data: got tap0=%0d tap18=%0d tap36=%0d required %0d %0d %0d",
                             TAP[0], TAP[18], TAP[NTAPS-1], mon_e.newest, mon_e.middle, mon_e.oldest);
                end else begin
                    $display("window ok: tap0=%0d tap18=%0d tap36=%0d", TAP[0], TAP[18], TAP[NTAPS-1]);
                end
            end
        end
    end

    task automatic test_reset();
        int nz;
        checks++;
        if (S_READY !== 1'b0 || C_READY !== 1'b1 || COEFF_OK !== 1'b0 || WIN_VALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got rdy=%b crdy=%b ok=%b wv=%b required 0 1 0 0",
                     S_READY, C_READY, COEFF_OK, WIN_VALID);
        end
        nz = 0;
        for (int k = 0; k < NTAPS; k++) if (TAP[k] !== '0 || COEFF[k] !== '0) nz++;
        checks++;
        if (nz != 0) begin
            failures++;
            $display("FAIL reset_zero: got %0d nonzero tap/coeff entries required 0", nz);
        end
        EN = 1'b1;
        repeat (3) tick();
        checks++;
        if (S_READY !== 1'b0 || C_READY !== 1'b1) begin
            failures++;
            $display("FAIL load_hold: got rdy=%b crdy=%b required 0 1", S_READY, C_READY);
        end
        EN = 1'b0;
        tick();
        $display("reset test done");
    endtask

    task automatic test_coeff_load();
        int bad;
        for (int a = 0; a < NUNIQ; a++) begin
            if (a == NUNIQ - 1) begin
                checks++;
                if (COEFF_OK !== 1'b0) begin
                    failures++;
                    $display("FAIL coeff_ok_early: got %b required 0", COEFF_OK);
                end
            end
            C_WR = 1'b1; C_ADDR = AWIDTH'(a); C_DATA = CWIDTH'(10 * a);
            cm[a] = CWIDTH'(10 * a);
            tick();
            $display("coeff write addr=%0d data=%0d", a, 10 * a);
        end
        C_WR = 1'b0;
        checks++;
        if (COEFF_OK !== 1'b1) begin
            failures++;
            $display("FAIL coeff_ok: got %b required 1", COEFF_OK);
        end
        checks++;
        if (COEFF[3] !== 11'sd30 || COEFF[33] !== 11'sd30 || COEFF[18] !== 11'sd180) begin
            failures++;
            $display("FAIL coeff_mirror: got c3=%0d c33=%0d c18=%0d required 30 30 180",
                     COEFF[3], COEFF[33], COEFF[18]);
        end
        bad = 0;
        for (int k = 0; k < NTAPS; k++) if (COEFF[k] !== cm[(k < NUNIQ) ? k : NTAPS-1-k]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL coeff_vector: got %0d mismatching entries required 0", bad);
        end
    endtask

    task automatic test_coeff_edge();
        int bad;
        C_WR = 1'b1; C_ADDR = 5'd25; C_DATA = 11'sd7;
        tick();
        C_WR = 1'b0;
        $display("coeff write addr=25 data=7 (out of range)");
        bad = 0;
        for (int k = 0; k < NTAPS; k++) if (COEFF[k] !== cm[(k < NUNIQ) ? k : NTAPS-1-k]) bad++;
        checks++;
        if (bad != 0 || COEFF_OK !== 1'b1) begin
            failures++;
            $display("FAIL coeff_oob: got %0d changed entries ok=%b required 0 1", bad, COEFF_OK);
        end
        C_WR = 1'b1; C_ADDR = 5'd5; C_DATA = 11'sd5;
        tick();
        C_DATA = -11'sd5;
        cm[5] = -11'sd5;
        tick();
        C_WR = 1'b0;
        $display("coeff write addr=5 data=5 then -5");
        checks++;
        if (COEFF[5] !== -11'sd5 || COEFF[31] !== -11'sd5) begin
            failures++;
            $display("FAIL coeff_rewrite: got c5=%0d c31=%0d required -5 -5", COEFF[5], COEFF[31]);
        end
    endtask

    task automatic test_stream();
        EN = 1'b1;
        tick();
        checks++;
        if (S_READY !== 1'b1 || C_READY !== 1'b0) begin
            failures++;
            $display("FAIL enter_fill: got rdy=%b crdy=%b required 1 0", S_READY, C_READY);
        end
        for (int i = 1; i <= NTAPS; i++) begin
            send(DWIDTH'(i));
            if (i == NTAPS - 1) begin
                checks++;
                if (WIN_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL win_early: got WIN_VALID=%b after 36 samples required 0", WIN_VALID);
                end
            end
        end
        checks++;
        if (WIN_VALID !== 1'b1 || TAP[0] !== 15'sd37 || TAP[NTAPS-1] !== 15'sd1) begin
            failures++;
            $display("FAIL first_window: got wv=%b tap0=%0d tap36=%0d required 1 37 1",
                     WIN_VALID, TAP[0], TAP[NTAPS-1]);
        end
        send(14'sd38);
        checks++;
        if (WIN_VALID !== 1'b1 || TAP[NTAPS-1] !== 15'sd2) begin
            failures++;
            $display("FAIL second_window: got wv=%b tap36=%0d required 1 2", WIN_VALID, TAP[NTAPS-1]);
        end
        // Coefficient write outside the load state must be ignored.
        C_WR = 1'b1; C_ADDR = 5'd0; C_DATA = 11'sd99;
        tick();
        C_WR = 1'b0;
        checks++;
        if (COEFF[0] !== cm[0] || COEFF[NTAPS-1] !== cm[0] || WIN_VALID !== 1'b0) begin
            failures++;
            $display("FAIL coeff_run_write: got c0=%0d c36=%0d wv=%b required %0d %0d 0",
                     COEFF[0], COEFF[NTAPS-1], WIN_VALID, cm[0], cm[0]);
        end
    endtask

    task automatic test_min_and_gap();
        send(-14'sd8192);
        checks++;
        if (TAP[0] !== 15'h6000) begin
            failures++;
            $display("FAIL min_sample: got tap0=%h required 6000", TAP[0]);
        end
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (WIN_VALID !== 1'b0 || TAP[0] !== 15'h6000) begin
                failures++;
                $display("FAIL gap_cycle%0d: got wv=%b tap0=%h required 0 6000", g, WIN_VALID, TAP[0]);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL gap_pending: got %0d windows outstanding required 0", sb.size());
        end
    endtask

    task automatic refill_check(input string tag, input int base);
        for (int i = 0; i < NTAPS; i++) begin
            send(DWIDTH'(base + i));
            if (i == NTAPS - 2) begin
                checks++;
                if (WIN_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_early: got WIN_VALID=%b after 36 samples required 0", tag, WIN_VALID);
                end
            end
        end
        checks++;
        if (WIN_VALID !== 1'b1 || TAP[NTAPS-1] !== tap_t'(base)) begin
            failures++;
            $display("FAIL %s_full: got wv=%b tap36=%0d required 1 %0d", tag, WIN_VALID, TAP[NTAPS-1], base);
        end
    endtask

    task automatic test_en_drop();
        int nz;
        EN = 1'b0; S_VALID = 1'b1; S_DATA = 14'sd555;
        #1;
        checks++;
        if (S_READY !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_ready: got %b required 0", S_READY);
        end
        tick();
        S_VALID = 1'b0;
        model_win.delete();
        nz = 0;
        for (int k = 0; k < NTAPS; k++) if (TAP[k] !== '0) nz++;
        checks++;
        if (nz != 0 || COEFF_OK !== 1'b1 || C_READY !== 1'b1 || WIN_VALID !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_state: got nonzero=%0d ok=%b crdy=%b wv=%b required 0 1 1 0",
                     nz, COEFF_OK, C_READY, WIN_VALID);
        end
        EN = 1'b1;
        tick();
        refill_check("en_refill", 100);
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL en_pending: got %0d windows outstanding required 0", sb.size());
        end
    endtask

`ifdef FIR_FEED_FLUSH_EN
    task automatic test_flush();
        int nz;
        for (int i = 0; i < 20; i++) send(DWIDTH'(300 + i));
        FLUSH = 1'b1; S_VALID = 1'b1; S_DATA = 14'sd777;
        #1;
        checks++;
        if (S_READY !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: got %b required 0", S_READY);
        end
        tick();
        FLUSH = 1'b0; S_VALID = 1'b0;
        model_win.delete();
        nz = 0;
        for (int k = 0; k < NTAPS; k++) if (TAP[k] !== '0) nz++;
        checks++;
        if (nz != 0 || WIN_VALID !== 1'b0 || S_READY !== 1'b1 || COEFF_OK !== 1'b1) begin
            failures++;
            $display("FAIL flush_state: got nonzero=%0d wv=%b rdy=%b ok=%b required 0 0 1 1",
                     nz, WIN_VALID, S_READY, COEFF_OK);
        end
        refill_check("flush_refill", 400);
        tick();
    endtask
`endif

    task automatic test_reset_mid_fill();
        int nz;
        EN = 1'b0;
        tick();
        model_win.delete();
        EN = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send(DWIDTH'(50 + i));
        #2;
        RST_N = 1'b0;
        #1;
        nz = 0;
        for (int k = 0; k < NTAPS; k++) if (TAP[k] !== '0 || COEFF[k] !== '0) nz++;
        checks++;
        if (nz != 0 || COEFF_OK !== 1'b0 || WIN_VALID !== 1'b0 || S_READY !== 1'b0 || C_READY !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got nonzero=%0d ok=%b wv=%b rdy=%b crdy=%b required 0 0 0 0 1",
                     nz, COEFF_OK, WIN_VALID, S_READY, C_READY);
        end
        model_win.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_pending: got %0d windows outstanding required 0", sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; EN = 1'b0; S_DATA = '0; S_VALID = 1'b0;
        C_WR = 1'b0; C_ADDR = '0; C_DATA = '0;
`ifdef FIR_FEED_FLUSH_EN
        FLUSH = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();
        test_reset();
        test_coeff_load();
        test_coeff_edge();
        test_stream();
        test_min_and_gap();
        test_en_drop();
`ifdef FIR_FEED_FLUSH_EN
        test_flush();
`endif
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
